// File: rtl/fp_mon_pkg.sv
// Shared rule indices and exponent helpers for the floating-point status monitor.
package fp_mon_pkg;

  localparam int RULE_ZERO = 0;
  localparam int RULE_INF  = 1;
  localparam int RULE_NAN  = 2;
  localparam int RULE_TINY = 3;
  localparam int RULE_HUGE = 4;
  localparam int NUM_RULES = 5;

  function automatic logic [31:0] exp_all_ones(input int exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_mon_delay.sv
// Fixed-depth shift register that realigns operand launch info with the multiplier result.
module fp_mon_delay #(
  parameter int DATA_W = 17,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] pipe_p [STAGES];

  // Cleared on reset so launches in flight never reach the checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= d;
      for (int i = 1; i < STAGES; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign q = pipe_p[STAGES-1];

endmodule

// File: rtl/fp_status_monitor.sv
// Checks multiplier status flags against the result/operand exponents and logs violations.
// Optional first-failure capture is built when FP_STATUS_MONITOR_CAPTURE_EN is defined.
module fp_status_monitor
  import fp_mon_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mon_en,
  input  logic                       in_valid,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic [W-1:0]               z,
  input  logic [7:0]                 status,
  input  logic                       clr,
  output logic [NUM_RULES-1:0]       err_sticky,
  output logic                       err_any,
  output logic                       irq,
  output logic [NUM_RULES*CNT_W-1:0] viol_cnt,
  output logic                       cap_valid,
  output logic [NUM_RULES-1:0]       cap_rule,
  output logic [W-1:0]               cap_z,
  output logic [CNT_W-1:0]           cap_time
);

  localparam int                 DLY_W    = 1 + 2*EXP_W;
  localparam logic [EXP_W-1:0]   EXP_ONES = EXP_W'(exp_all_ones(EXP_W));
  localparam logic [EXP_W-1:0]   EXP_HUGE = EXP_ONES - 1'b1;
  localparam logic [EXP_W-1:0]   EXP_ONE  = EXP_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [DLY_W-1:0]     dly_d_p0, dly_q;
  logic                 chk_v;
  logic [EXP_W-1:0]     exp_a_d, exp_b_d, exp_z;
  logic [MAN_W-1:0]     mant_z;
  logic [NUM_RULES-1:0] rule_fail_p0, sticky_base;
  logic [NUM_RULES-1:0] sticky_p1;
  logic                 irq_p1;
  logic [CNT_W-1:0]     ts_p1;
  logic                 unused_bits;

  assign dly_d_p0 = {in_valid, a[W-2 -: EXP_W], b[W-2 -: EXP_W]};

  fp_mon_delay #(.DATA_W(DLY_W), .STAGES(LATENCY)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dly_d_p0),
    .q     (dly_q)
  );

  assign chk_v   = dly_q[DLY_W-1];
  assign exp_a_d = dly_q[2*EXP_W-1 -: EXP_W];
  assign exp_b_d = dly_q[EXP_W-1:0];
  assign exp_z   = z[W-2 -: EXP_W];
  assign mant_z  = z[MAN_W-1:0];

  assign unused_bits = ^{status[7:5], a[W-1], a[MAN_W-1:0], b[W-1], b[MAN_W-1:0], z[W-1]};

  // Stage p0: rule evaluation on the realigned launch and the current result.
  always_comb begin
    rule_fail_p0 = '0;
    if (chk_v && mon_en) begin
      rule_fail_p0[RULE_ZERO] = status[RULE_ZERO] && (exp_z != '0);
      rule_fail_p0[RULE_INF]  = status[RULE_INF]  && (exp_z != EXP_ONES);
      rule_fail_p0[RULE_NAN]  = status[RULE_NAN]  &&
                                !(((exp_a_d == '0) && (exp_b_d == EXP_ONES)) ||
                                  ((exp_a_d == EXP_ONES) && (exp_b_d == '0)));
      rule_fail_p0[RULE_TINY] = status[RULE_TINY] &&
                                !((exp_z == '0) || ((exp_z == EXP_ONE) && (mant_z == '0)));
      rule_fail_p0[RULE_HUGE] = status[RULE_HUGE] &&
                                !((exp_z == EXP_ONES) || ((exp_z == EXP_HUGE) && (mant_z == '1)));
    end
  end

  // Clear is folded in before the new violations so both land in the same cycle.
  assign sticky_base = clr ? '0 : sticky_p1;

  // Stage p1: registered log of violations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_p1 <= '0;
      irq_p1    <= 1'b0;
      ts_p1     <= '0;
    end else begin
      sticky_p1 <= sticky_base | rule_fail_p0;
      irq_p1    <= (|rule_fail_p0) && !(|sticky_base);
      ts_p1     <= clr ? '0 : ts_p1 + 1'b1;
    end
  end

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_cnt
    logic [CNT_W-1:0] cnt_p1, cnt_base;
    assign cnt_base = clr ? '0 : cnt_p1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_p1 <= '0;
      else        cnt_p1 <= rule_fail_p0[r] ? sat_inc(cnt_base) : cnt_base;
    end
    assign viol_cnt[r*CNT_W +: CNT_W] = cnt_p1;
  end

  assign err_sticky = sticky_p1;
  assign err_any    = |sticky_p1;
  assign irq        = irq_p1;

`ifdef FP_STATUS_MONITOR_CAPTURE_EN
  logic                 cap_valid_p1, cap_valid_base;
  logic [NUM_RULES-1:0] cap_rule_p1;
  logic [W-1:0]         cap_z_p1;
  logic [CNT_W-1:0]     cap_time_p1, ts_base;

  assign cap_valid_base = clr ? 1'b0 : cap_valid_p1;
  assign ts_base        = clr ? '0 : ts_p1;

  // First violation after reset/clear is frozen until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_p1 <= 1'b0;
      cap_rule_p1  <= '0;
      cap_z_p1     <= '0;
      cap_time_p1  <= '0;
    end else if (!cap_valid_base && (|rule_fail_p0)) begin
      cap_valid_p1 <= 1'b1;
      cap_rule_p1  <= rule_fail_p0;
      cap_z_p1     <= z;
      cap_time_p1  <= ts_base;
    end else if (clr) begin
      cap_valid_p1 <= 1'b0;
      cap_rule_p1  <= '0;
      cap_z_p1     <= '0;
      cap_time_p1  <= '0;
    end
  end

  assign cap_valid = cap_valid_p1;
  assign cap_rule  = cap_rule_p1;
  assign cap_z     = cap_z_p1;
  assign cap_time  = cap_time_p1;
`else
  assign cap_valid = 1'b0;
  assign cap_rule  = '0;
  assign cap_z     = '0;
  assign cap_time  = '0;
`endif

endmodule

// File: tb/tb_fp_status_monitor.sv
// Scoreboard bench for fp_status_monitor (EXP_W=8, MAN_W=23, LATENCY=3, CNT_W=16).
module tb_fp_status_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0, z = '0;
  logic [7:0]  status = '0;
  logic        clr = 1'b0;
  logic [4:0]  err_sticky;
  logic        err_any, irq;
  logic [79:0] viol_cnt;
  logic        cap_valid;
  logic [4:0]  cap_rule;
  logic [31:0] cap_z;
  logic [15:0] cap_time;

  fp_status_monitor #(.EXP_W(8), .MAN_W(23), .LATENCY(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_en     (mon_en),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .z          (z),
    .status     (status),
    .clr        (clr),
    .err_sticky (err_sticky),
    .err_any    (err_any),
    .irq        (irq),
    .viol_cnt   (viol_cnt),
    .cap_valid  (cap_valid),
    .cap_rule   (cap_rule),
    .cap_z      (cap_z),
    .cap_time   (cap_time)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  sticky;
    logic        any;
    logic        irq;
    logic [79:0] cnt;
    logic        cv;
    logic [4:0]  cr;
    logic [31:0] cz;
    logic [15:0] ct;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state
  logic [4:0]  m_sticky;
  logic        m_irq;
  int          m_cnt[5];
  int          m_ts;
  logic        m_cv;
  logic [4:0]  m_cr;
  logic [31:0] m_cz;
  logic [15:0] m_ct;
  logic        hv[3];
  logic [7:0]  hea[3], heb[3];

  task automatic chk_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [4:0] model_rules(logic [31:0] zz, logic [7:0] st,
                                              logic [7:0] ea, logic [7:0] eb);
    logic [7:0]  ez;
    logic [22:0] mz;
    logic [4:0]  r;
    ez = zz[30:23];
    mz = zz[22:0];
    r[0] = st[0] && !(ez == 8'h00);
    r[1] = st[1] && !(ez == 8'hFF);
    r[2] = st[2] && !((ea == 8'h00 && eb == 8'hFF) || (ea == 8'hFF && eb == 8'h00));
    r[3] = st[3] && !(ez == 8'h00 || (ez == 8'h01 && mz == 23'h0));
    r[4] = st[4] && !(ez == 8'hFF || (ez == 8'hFE && mz == 23'h7FFFFF));
    return r;
  endfunction

  task automatic model_reset();
    m_sticky = '0; m_irq = 1'b0; m_ts = 0;
    m_cv = 1'b0; m_cr = '0; m_cz = '0; m_ct = '0;
    for (int r = 0; r < 5; r++) m_cnt[r] = 0;
    for (int i = 0; i < 3; i++) begin hv[i] = 1'b0; hea[i] = '0; heb[i] = '0; end
  endtask

  task automatic model_step(input bit iv, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [31:0] zz, input logic [7:0] st,
                            input bit c, input bit en, input bit rn);
    logic [4:0] v;
    exp_t       e;
    if (!rn) begin
      model_reset();
    end else begin
      v = (hv[2] && en) ? model_rules(zz, st, hea[2], heb[2]) : 5'b0;
      if (c) begin
        m_sticky = '0; m_ts = 0;
        for (int r = 0; r < 5; r++) m_cnt[r] = 0;
        m_cv = 1'b0; m_cr = '0; m_cz = '0; m_ct = '0;
      end
      m_irq = (v != 5'b0) && (m_sticky == 5'b0);
      m_sticky = m_sticky | v;
      for (int r = 0; r < 5; r++)
        if (v[r] && m_cnt[r] < 65535) m_cnt[r]++;
`ifdef FP_STATUS_MONITOR_CAPTURE_EN
      if (!m_cv && v != 5'b0) begin
        m_cv = 1'b1; m_cr = v; m_cz = zz; m_ct = 16'(m_ts);
      end
`endif
      m_ts = (m_ts + 1) % 65536;
      hv[2] = hv[1]; hea[2] = hea[1]; heb[2] = heb[1];
      hv[1] = hv[0]; hea[1] = hea[0]; heb[1] = heb[0];
      hv[0] = iv;    hea[0] = ea;     heb[0] = eb;
    end
    e.sticky = m_sticky;
    e.any    = |m_sticky;
    e.irq    = m_irq;
    for (int r = 0; r < 5; r++) e.cnt[r*16 +: 16] = 16'(m_cnt[r]);
    e.cv = m_cv; e.cr = m_cr; e.cz = m_cz; e.ct = m_ct;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_val("err_sticky", 80'(err_sticky), 80'(e.sticky));
      chk_val("err_any",    80'(err_any),    80'(e.any));
      chk_val("irq",        80'(irq),        80'(e.irq));
      chk_val("viol_cnt",   viol_cnt,        e.cnt);
      chk_val("cap_valid",  80'(cap_valid),  80'(e.cv));
      chk_val("cap_rule",   80'(cap_rule),   80'(e.cr));
      chk_val("cap_z",      80'(cap_z),      80'(e.cz));
      chk_val("cap_time",   80'(cap_time),   80'(e.ct));
    end
  endtask

  // Compare the previous cycle's outputs, then drive the next cycle and log its expectation.
  task automatic step(input bit iv, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [31:0] zz, input logic [7:0] st,
                      input bit c = 1'b0, input bit en = 1'b1, input bit rn = 1'b1);
    @(negedge clk);
    pop_check();
    rst_n    = rn;
    mon_en   = en;
    in_valid = iv;
    a        = {1'b0, ea, 23'h12345};
    b        = {1'b1, eb, 23'h54321};
    z        = zz;
    status   = st;
    clr      = c;
    model_step(iv, ea, eb, zz, st, c, en, rn);
  endtask

  task automatic launch(input logic [7:0] ea, input logic [7:0] eb);
    step(1'b1, ea, eb, 32'h0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00);
  endtask

  logic [7:0] eset[5] = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
  logic [7:0] zset[5] = '{8'h00, 8'h01, 8'h05, 8'hFE, 8'hFF};

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h80, 8'hFF, 32'h0, 8'h1F, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle();

    // Valid nan: zero times infinity
    launch(8'h00, 8'hFF); idle(); idle();
    step(1'b0, 8'h00, 8'h00, 32'h7FC00000, 8'h04);
    idle();
    chk_val("nan_ok_any", 80'(err_any), 80'(0));

    // Invalid nan
    launch(8'h80, 8'hFF); idle(); idle();
    step(1'b0, 8'h00, 8'h00, 32'h7FC00000, 8'h04);
    idle();
    chk_val("nan_bad_sticky2", 80'(err_sticky[2]), 80'(1));
    chk_val("nan_bad_cnt2",    80'(viol_cnt[32 +: 16]), 80'(1));
    chk_val("nan_bad_irq_hi",  80'(irq), 80'(1));
    idle();
    chk_val("nan_bad_irq_lo",  80'(irq), 80'(0));

    // Huge boundary
    launch(8'h80, 8'h80); launch(8'h80, 8'h80); idle();
    step(1'b0, 8'h00, 8'h00, 32'h7F7FFFFF, 8'h10);
    step(1'b0, 8'h00, 8'h00, 32'h7F7FFFFE, 8'h10);
    chk_val("huge_ok_sticky4",  80'(err_sticky[4]), 80'(0));
    idle();
    chk_val("huge_bad_sticky4", 80'(err_sticky[4]), 80'(1));
    chk_val("huge_no_2nd_irq",  80'(irq), 80'(0));

    // Tiny and huge together with a clear
    launch(8'h80, 8'h80); idle(); idle();
    step(1'b0, 8'h00, 8'h00, {1'b0, 8'h05, 23'h0}, 8'h18, 1'b1);
    idle();
    chk_val("clr_cnts", viol_cnt, {16'd1, 16'd1, 48'd0});
    chk_val("clr_irq",  80'(irq), 80'(1));
`ifdef FP_STATUS_MONITOR_CAPTURE_EN
    chk_val("clr_cap_rule", 80'(cap_rule), 80'(5'b11000));
`else
    chk_val("cap_tied_rule", 80'(cap_rule), 80'(0));
`endif

    // Mixed traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0),
           eset[$urandom_range(0, 4)], eset[$urandom_range(0, 4)],
           {1'b0, zset[$urandom_range(0, 4)],
            ($urandom_range(0, 2) == 0) ? 23'h0 :
            ($urandom_range(0, 1) == 0) ? 23'h7FFFFF : 23'($urandom)},
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0));
    end

    // Reset mid-pipeline discards the launch
    launch(8'h80, 8'hFF);
    step(1'b0, 8'h00, 8'h00, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 8'h00, 8'h00, 32'h7FC00000, 8'h04);
    idle();
    chk_val("rst_any",   80'(err_any), 80'(0));
    chk_val("rst_cnt",   viol_cnt, 80'(0));
    chk_val("rst_irq",   80'(irq), 80'(0));
    chk_val("rst_cap_v", 80'(cap_valid), 80'(0));

    // Zero-rule counter saturation
    step(1'b1, 8'h80, 8'h80, {1'b0, 8'h01, 23'h0}, 8'h01, 1'b1);
    for (int i = 0; i < 65540; i++)
      step(1'b1, 8'h80, 8'h80, {1'b0, 8'h01, 23'h0}, 8'h01);
    idle();
    chk_val("sat_cnt0", 80'(viol_cnt[15:0]), 80'(16'hFFFF));

    @(negedge clk);
    pop_check();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_status_monitor.md
FP_STATUS_MONITOR -- requirements
Module: fp_status_monitor

Interface
REQ-001 Parameter EXP_W, default 8: exponent width; the operand width is W = 1+EXP_W+MAN_W.
REQ-002 Parameter MAN_W, default 23: mantissa width.
REQ-003 Parameter LATENCY, default 3, legal range 1..8: cycles from operand launch to result and status.
REQ-004 Parameter CNT_W, default 16: width of each violation counter and of the timestamp.
REQ-005 clk  input  1  single clock; all flops sample on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 mon_en  input  1  checking enable.
REQ-008 in_valid  input  1  operands a and b are launched this cycle.
REQ-009 a, b  input  W each  operands of the monitored multiplier.
REQ-010 z  input  W  result, valid LATENCY cycles after launch.
REQ-011 status  input  8  flags: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge.
REQ-012 clr  input  1  single-cycle synchronous clear of counters, sticky bits and capture.
REQ-013 err_sticky  output  5  per-rule sticky violation bits, in the same bit order as status[4:0].
REQ-014 err_any  output  1  OR of err_sticky.
REQ-015 irq  output  1  one-cycle pulse on each 0->1 transition of err_any.
REQ-016 viol_cnt  output  5*CNT_W  per-rule saturating counters; rule r occupies bits [r*CNT_W +: CNT_W].
REQ-017 cap_valid, cap_rule[4:0], cap_z[W-1:0], cap_time[CNT_W-1:0]  outputs  first-failure capture.

Function
REQ-018 A delay line of depth LATENCY SHALL carry in_valid, exp_a and exp_b; the delayed valid is chk_v.
REQ-019 Checks SHALL be evaluated only in cycles where chk_v=1 and mon_en=1; in all other cycles they SHALL record nothing.
REQ-020 The delay line SHALL shift every cycle, regardless of mon_en.
REQ-021 Rule zero: status[0] SHALL imply that exp_z is all zeros.
REQ-022 Rule inf: status[1] SHALL imply that exp_z is all ones.
REQ-023 Rule nan: status[2] SHALL imply that, in the delayed operands, one exponent was all zeros and the other was all ones.
REQ-024 Rule tiny: status[3] SHALL imply that exp_z==0, or that exp_z==1 with mant_z==0.
REQ-025 Rule huge: status[4] SHALL imply that exp_z is all ones, or that exp_z is all-ones-minus-1 with mant_z all ones.
REQ-026 Each rule violation SHALL set its err_sticky bit and increment its counter in the following cycle (1-cycle registered latency).
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-028 Several rules failing in the same cycle SHALL each be recorded independently.
REQ-029 When clr and a violation occur in the same cycle, the clear SHALL take effect first: the violating counter becomes 1, its sticky bit is set, and irq pulses.
REQ-030 A free-running timestamp of CNT_W bits SHALL count every cycle, wrap at its maximum, and be cleared by clr.
REQ-031 Without a clr, irq SHALL pulse at most once, even if later violations occur.

Reset
REQ-032 While rst_n=0, all outputs, counters, the timestamp and the delay line SHALL be 0, so in-flight launches are discarded.
REQ-033 After the release of rst_n, chk_v SHALL stay 0 for at least LATENCY cycles, until new launches reach the end of the delay line.

Configuration
REQ-034 Macro FP_STATUS_MONITOR_CAPTURE_EN SHALL control the first-failure capture feature.
REQ-035 With FP_STATUS_MONITOR_CAPTURE_EN defined, the first violating cycle after reset or clr SHALL load the capture registers:
  cap_valid=1, cap_rule = vector of the failing rules, cap_z = z, cap_time = timestamp.
  The capture SHALL then hold until clr or reset.
REQ-036 Without FP_STATUS_MONITOR_CAPTURE_EN, the cap_* ports SHALL exist and SHALL be tied to 0, and no capture flops SHALL be built.

Structure
REQ-037 A shared package fp_mon_pkg SHALL hold:
  - the rule index constants RULE_ZERO=0, RULE_INF=1, RULE_NAN=2, RULE_TINY=3, RULE_HUGE=4 and NUM_RULES=5;
  - a function that returns the all-ones exponent for EXP_W.
REQ-038 The delay line SHALL be a sub-module, fp_mon_delay, parametrised by width and depth.

Verification
REQ-039 With LATENCY=3 and mon_en=1:
  - launch a.exp=0x00, b.exp=0xFF;
  - 3 cycles later drive status=0x04 (nan);
  - required: no error.
REQ-040 With the same launch, drive status=0x04 when a.exp=0x80, b.exp=0xFF:
  - err_sticky[2]=1 and viol_cnt[2]=1 one cycle later;
  - irq pulses for exactly 1 cycle.
REQ-041 Drive status=0x10 (huge) with z=0x7F7FFFFF: no error. Drive status=0x10 with z=0x7F7FFFFE: err_sticky[4]=1.
REQ-042 Force 65536 zero-rule violations (z.exp=0x01, status=0x01) with CNT_W=16: viol_cnt[0] ends at 0xFFFF and does not wrap.
REQ-043 Violate tiny and huge in the same cycle as a clr pulse:
  - viol_cnt[3]=1 and viol_cnt[4]=1, all other counters 0;
  - with the capture macro defined, cap_rule=5'b11000.
REQ-044 Launch with in_valid=1, then assert rst_n=0 mid-pipeline for 1 cycle: no check occurs for that launch, and all outputs read 0.
